// File: rtl/bottling_ctrl_gen2.sv
// bottling_ctrl_gen2: bottling station sequencer with cork tray/dispenser bookkeeping,
// alarm handling and a BCD dozen tally.
module bottling_ctrl_gen2 #(
   parameter int TRAY_CAP     = 20,
   parameter int REFILL_QTY   = 20,
   parameter int LOW_MARK     = 5,
   parameter int DISP_STOCK   = 60,
   parameter int SEAL_CYCLES  = 4,
   parameter int FILL_TIMEOUT = 1024,
   parameter int BATCH        = 12,
   parameter int CNT_DIGITS   = 2,
   localparam int TW = $clog2(TRAY_CAP + 1),
   localparam int SW = $clog2(DISP_STOCK + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    run,
   input  logic                    PG,
   input  logic                    CH,
   input  logic                    alarm_clr,
   input  logic                    stock_load,
   output logic                    M,
   output logic                    EV,
   output logic                    VE,
   output logic                    AD,
   output logic                    A,
   output logic [1:0]              alarm_code,
   output logic                    GP,
   output logic [TW-1:0]           tray_count,
   output logic [SW-1:0]           stock_count,
   output logic [4*CNT_DIGITS-1:0] dozen_bcd
);
   localparam int FW = $clog2(FILL_TIMEOUT + 1);
   localparam int CW = $clog2(SEAL_CYCLES + 1);
   localparam int BW = $clog2(BATCH + 1);
   typedef enum logic [2:0] {IDLE, MOVE, FILL, SEAL, EJECT, ALARM} state_t;
   state_t state, state_nx;
   logic [1:0] code_nx;
   logic [FW-1:0] fill_t;
   logic [CW-1:0] seal_t;
   logic [BW-1:0] batch;
   logic gp_now, refill, carry;
   int room, add;
   logic [TW-1:0] tray_nx;
   logic [SW-1:0] stock_nx;
   logic [4*CNT_DIGITS-1:0] bcd_inc;

   always_comb begin
      state_nx = state;
      code_nx = alarm_code;
      case (state)
         IDLE:  state_nx = run && tray_count != '0 && !A ? MOVE : IDLE;
         MOVE:  state_nx = PG ? FILL : !run ? IDLE : MOVE;
         FILL: begin
            if (CH) state_nx = SEAL;
            else if (fill_t == FW'(FILL_TIMEOUT - 1)) begin
               state_nx = ALARM;
               code_nx = 2'b01;
            end
         end
         SEAL:  state_nx = seal_t == CW'(SEAL_CYCLES - 1) ? EJECT : SEAL;
         EJECT: begin
            if (!PG) begin
               if (tray_count == '0 && stock_count == '0) begin
                  state_nx = ALARM;
                  code_nx = 2'b10;
               end else state_nx = run && tray_count != '0 ? MOVE : IDLE;
            end
         end
         ALARM: begin
            if (alarm_clr && (alarm_code == 2'b01 || stock_count != '0)) begin
               state_nx = IDLE;
               code_nx = 2'b00;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Refill amount is bounded by request size, dispenser content and free tray room.
   always_comb begin
      gp_now = state == SEAL && state_nx == EJECT;
      room = TRAY_CAP - int'(tray_count);
      add = REFILL_QTY < int'(stock_count) ? REFILL_QTY : int'(stock_count);
      add = room < add ? room : add;
      refill = int'(tray_count) <= LOW_MARK && stock_count != '0 && !AD;
      tray_nx = TW'(int'(tray_count) - int'(gp_now) + (refill ? add : 0));
      stock_nx = stock_load ? SW'(DISP_STOCK) : stock_count - (refill ? SW'(add) : '0);
      carry = 1'b1;
      bcd_inc = dozen_bcd;
      for (int i = 0; i < CNT_DIGITS; i++) begin
         bcd_inc[4*i+:4] = carry ? (dozen_bcd[4*i+:4] == 4'd9 ? 4'd0 : dozen_bcd[4*i+:4] + 4'd1) : dozen_bcd[4*i+:4];
         carry = carry && dozen_bcd[4*i+:4] == 4'd9;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         M <= 1'b0;
         EV <= 1'b0;
         VE <= 1'b0;
         A <= 1'b0;
         AD <= 1'b0;
         GP <= 1'b0;
         alarm_code <= 2'b00;
         tray_count <= TW'(TRAY_CAP);
         stock_count <= SW'(DISP_STOCK);
         dozen_bcd <= '0;
         batch <= '0;
         fill_t <= '0;
         seal_t <= '0;
      end else begin
         state <= state_nx;
         M <= state_nx == MOVE || state_nx == EJECT;
         EV <= state_nx == FILL;
         VE <= state_nx == SEAL;
         A <= state_nx == ALARM;
         AD <= refill;
         GP <= gp_now;
         alarm_code <= code_nx;
         tray_count <= tray_nx;
         stock_count <= stock_nx;
         fill_t <= state == FILL ? fill_t + FW'(1) : '0;
         seal_t <= state == SEAL ? seal_t + CW'(1) : '0;
         if (gp_now) begin
            batch <= batch == BW'(BATCH - 1) ? '0 : batch + BW'(1);
            dozen_bcd <= batch == BW'(BATCH - 1) ? bcd_inc : dozen_bcd;
         end
      end
   end
endmodule

// File: tb/tb_bottling_ctrl_gen2.sv
// tb_bottling_ctrl_gen2: directed bench; u0 uses default parameters, u1 a short
// fill watchdog and a one-digit tally counting pairs of bottles.
module tb_bottling_ctrl_gen2;
   logic clk = 1'b0, reset = 1'b1;
   logic [1:0] run = '0, pg = '0, ch = '0, clr = '0, ld = '0;
   logic [1:0] m, ev, ve, ad, a, gp;
   logic [1:0] code0, code1;
   logic [4:0] tray0, tray1;
   logic [5:0] stock0, stock1;
   logic [7:0] dozen0;
   logic [3:0] dozen1;
   int n_cmp = 0, n_bad = 0, gp_n0 = 0, ad_n0 = 0;

   always #5 clk = ~clk;

   always @(negedge clk) begin
      gp_n0 <= gp_n0 + int'(gp[0]);
      ad_n0 <= ad_n0 + int'(ad[0]);
   end

   bottling_ctrl_gen2 u0 (
      .clk(clk), .reset(reset), .run(run[0]), .PG(pg[0]), .CH(ch[0]),
      .alarm_clr(clr[0]), .stock_load(ld[0]), .M(m[0]), .EV(ev[0]), .VE(ve[0]),
      .AD(ad[0]), .A(a[0]), .alarm_code(code0), .GP(gp[0]), .tray_count(tray0),
      .stock_count(stock0), .dozen_bcd(dozen0)
   );

   bottling_ctrl_gen2 #(.FILL_TIMEOUT(16), .BATCH(2), .CNT_DIGITS(1)) u1 (
      .clk(clk), .reset(reset), .run(run[1]), .PG(pg[1]), .CH(ch[1]),
      .alarm_clr(clr[1]), .stock_load(ld[1]), .M(m[1]), .EV(ev[1]), .VE(ve[1]),
      .AD(ad[1]), .A(a[1]), .alarm_code(code1), .GP(gp[1]), .tray_count(tray1),
      .stock_count(stock1), .dozen_bcd(dozen1)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One bottle with PG/CH as early as possible; t returns the tray count seen with GP.
   task automatic bottle(input int s, output int t);
      int k;
      pg[s] = 1'b1;
      ch[s] = 1'b1;
      k = 0;
      while (!gp[s] && k < 50) begin
         tick();
         k++;
      end
      chk("bottle_gp", int'(gp[s]), 1);
      t = s != 0 ? int'(tray1) : int'(tray0);
      pg[s] = 1'b0;
      ch[s] = 1'b0;
      tick();
   endtask

   initial begin
      int t, n;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_outs", int'({m[0], ev[0], ve[0], ad[0], a[0], gp[0]}), 0);
      chk("rst_code", int'(code0), 0);
      chk("rst_tray", int'(tray0), 20);
      chk("rst_stock", int'(stock0), 60);
      chk("rst_dozen", int'(dozen0), 0);
      reset = 1'b0;
      tick();
      run[0] = 1'b1;
      tick();
      chk("move_m", int'(m[0]), 1);
      pg[0] = 1'b1;
      tick();
      chk("fill_ev", int'(ev[0]), 1);
      repeat (4) tick();
      chk("fill_hold_ev", int'(ev[0]), 1);
      ch[0] = 1'b1;
      tick();
      ch[0] = 1'b0;
      n = 0;
      while (ve[0] && n < 20) begin
         n++;
         tick();
      end
      chk("ve_len", n, 4);
      chk("gp_eject", int'(gp[0]), 1);
      chk("tray_19", int'(tray0), 19);
      pg[0] = 1'b0;
      tick();
      chk("back_move_m", int'(m[0]), 1);
      chk("gp_single", int'(gp[0]), 0);
      tick();
      chk("gp_count1", gp_n0, 1);
      repeat (13) bottle(0, t);
      bottle(0, t);
      chk("tray_at_low", t, 5);
      chk("refill_ad", int'(ad[0]), 1);
      chk("refill_tray", int'(tray0), 20);
      chk("refill_stock", int'(stock0), 45);
      tick();
      chk("ad_clear", int'(ad[0]), 0);
      repeat (14) bottle(0, t);
      bottle(0, t);
      chk("tray_at_low2", t, 5);
      chk("refill2_tray", int'(tray0), 20);
      chk("refill2_stock", int'(stock0), 30);
      repeat (50) bottle(0, t);
      chk("exh_alarm", int'(a[0]), 1);
      chk("exh_code", int'(code0), 2);
      chk("exh_motor", int'(m[0]), 0);
      chk("exh_tray", int'(tray0), 0);
      chk("exh_stock", int'(stock0), 0);
      chk("exh_dozen", int'(dozen0), 6);
      chk("exh_gp_count", gp_n0, 80);
      chk("exh_ad_count", ad_n0, 4);
      clr[0] = 1'b1;
      tick();
      clr[0] = 1'b0;
      chk("clr_ignored", int'(a[0]), 1);
      ld[0] = 1'b1;
      tick();
      ld[0] = 1'b0;
      chk("load_stock", int'(stock0), 60);
      chk("load_tray", int'(tray0), 0);
      tick();
      chk("reload_tray", int'(tray0), 20);
      chk("reload_stock", int'(stock0), 40);
      chk("reload_ad", int'(ad[0]), 1);
      clr[0] = 1'b1;
      tick();
      clr[0] = 1'b0;
      chk("clr_alarm", int'(a[0]), 0);
      chk("clr_code", int'(code0), 0);
      chk("clr_idle_m", int'(m[0]), 0);
      tick();
      chk("idle_to_move", int'(m[0]), 1);
      bottle(0, t);
      chk("pre_rst_tray", int'(tray0), 19);
      pg[0] = 1'b1;
      tick();
      tick();
      chk("pre_rst_ev", int'(ev[0]), 1);
      reset = 1'b1;
      #1;
      chk("rst_mid_outs", int'({m[0], ev[0], ve[0], ad[0], a[0], gp[0]}), 0);
      chk("rst_mid_tray", int'(tray0), 20);
      chk("rst_mid_stock", int'(stock0), 60);
      chk("rst_mid_dozen", int'(dozen0), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      pg[0] = 1'b0;
      run[0] = 1'b0;
      repeat (8) tick();
      chk("rst_no_gp", gp_n0, 81);
      run[1] = 1'b1;
      tick();
      chk("u1_move_m", int'(m[1]), 1);
      pg[1] = 1'b1;
      tick();
      n = 0;
      while (ev[1] && n < 40) begin
         n++;
         tick();
      end
      chk("to_fill_len", n, 16);
      chk("to_alarm", int'(a[1]), 1);
      chk("to_code", int'(code1), 1);
      chk("to_ev_off", int'(ev[1]), 0);
      pg[1] = 1'b0;
      clr[1] = 1'b1;
      tick();
      clr[1] = 1'b0;
      chk("to_clr_alarm", int'(a[1]), 0);
      chk("to_clr_code", int'(code1), 0);
      chk("to_tray", int'(tray1), 20);
      for (int b = 1; b <= 20; b++) begin
         bottle(1, t);
         chk("bcd_digit", int'(dozen1), (b / 2) % 10);
      end
      chk("u1_tray", int'(tray1), 15);
      chk("u1_stock", int'(stock1), 45);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/bottling_ctrl_gen2.md
# bottling_ctrl_gen2

Parametrised second-generation controller for one wine bottling station. It merges the production sequencer, the cork tray and dispenser bookkeeping, alarm handling and the dozen tally into one synchronous block. Tray capacity, refill size, low-water mark, dispenser stock, seal duration, fill watchdog and BCD counter depth are all parameters. It sits after the input debounce/toggle stage and before the display multiplexer, which consumes `tray_count` and `dozen_bcd`.

## Interface
- `TRAY_CAP`, 20: maximum corks in the sealing tray.
- `REFILL_QTY`, 20: corks requested per dispenser activation.
- `LOW_MARK`, 5: refill is triggered when the tray count is at or below this value.
- `DISP_STOCK`, 60: dispenser content after reset or `stock_load`.
- `SEAL_CYCLES`, 4: number of cycles `VE` is held per bottle.
- `FILL_TIMEOUT`, 1024: maximum number of cycles allowed in FILL.
- `BATCH`, 12: bottles per counted unit (one dozen).
- `CNT_DIGITS`, 2: number of BCD digits in the dozen tally.
- Derived widths: TW = $clog2(TRAY_CAP+1), SW = $clog2(DISP_STOCK+1).
- Ports:
  - `clk` in 1: single clock; every register uses the rising edge.
  - `reset` in 1: asynchronous, active-high reset.
  - `run` in 1: level; 1 = station enabled.
  - `PG` in 1: bottle present at the station.
  - `CH` in 1: bottle full.
  - `alarm_clr` in 1: one-cycle pulse that acknowledges the alarm.
  - `stock_load` in 1: one-cycle pulse; dispenser refilled to `DISP_STOCK`.
  - `M`, `EV`, `VE` out 1 each: motor, fill valve, sealer.
  - `AD` out 1: dispenser activation, one-cycle pulse.
  - `A` out 1: alarm.
  - `alarm_code` out 2: 00 none, 01 fill timeout, 10 corks exhausted.
  - `GP` out 1: one-cycle pulse per finished bottle.
  - `tray_count` out TW: corks currently in the tray.
  - `stock_count` out SW: corks currently in the dispenser.
  - `dozen_bcd` out 4*CNT_DIGITS: BCD dozen tally, most significant digit in the top nibble.

## Operation
- FSM states: IDLE, MOVE, FILL, SEAL, EJECT, ALARM. Outputs are registered (Moore).
- IDLE: all actuators off. Goes to MOVE when `run`=1, `tray_count`>0 and `A`=0.
- MOVE: `M`=1. `PG`=1 → FILL. `run`=0 → IDLE. `PG` has priority when both occur.
- FILL: `EV`=1 and the fill timer runs.
  - `CH`=1 → SEAL.
  - Timer reaching FILL_TIMEOUT-1 without `CH` → ALARM with code 01.
  - `CH` wins if both happen in the same cycle.
- SEAL: `VE`=1 for exactly SEAL_CYCLES cycles, then EJECT.
  - On the SEAL→EJECT edge: `GP` pulses, `tray_count` decrements, and the batch counter advances.
- EJECT: `M`=1 until `PG`=0. Next state, in priority order:
  - ALARM, code 10, if `tray_count`=0 and `stock_count`=0.
  - Otherwise MOVE if `run`=1 and `tray_count`>0.
  - Otherwise IDLE.
- Clearing `run` mid-bottle (FILL, SEAL or EJECT) has no effect; the bottle finishes first.
- ALARM: `M`/`EV`/`VE`=0 and `A`=1.
  - `alarm_clr` with code 01 → IDLE.
  - `alarm_clr` with code 10 → IDLE only if `stock_count`>0; otherwise it is ignored.
  - `alarm_code` returns to 00 on leaving ALARM.
- Refill (runs independently of FSM state):
  - Condition: `tray_count` ≤ LOW_MARK, `stock_count`>0, and `AD` was 0 in the previous cycle. When met, `AD` pulses.
  - Amount: add = min(REFILL_QTY, `stock_count`, TRAY_CAP−`tray_count`), computed from current values.
  - Tray and stock are updated on the same edge that raises `AD`: `tray_count`+=add, `stock_count`−=add.
- Simultaneous refill and `GP`: tray_next = tray − 1 + add. It never exceeds TRAY_CAP and never underflows.
- `stock_load` sets `stock_count`=DISP_STOCK. A refill on the same edge uses the old stock value. The loaded value then overrides the refill subtraction.
- Batch counter: counts `GP` from 0 to BATCH−1.
  - At the wrap, `dozen_bcd` increments with per-digit carry at 9.
  - All digits 9 wraps to all 0.

## Timing
- Reset, asynchronous:
  - State IDLE; `M`/`EV`/`VE`/`AD`/`A`/`GP`=0; `alarm_code`=00.
  - `tray_count`=TRAY_CAP; `stock_count`=DISP_STOCK; `dozen_bcd`=0; batch counter and timers 0.
- Reset asserted mid-operation aborts the current bottle immediately. No `GP` is produced for that bottle.
- State-transition latency is 1 cycle from the sampled input to the changed outputs.
- `VE` is high for exactly SEAL_CYCLES consecutive cycles.
- `GP` is high for exactly 1 cycle, in the first EJECT cycle.
- `tray_count`, `stock_count` and `dozen_bcd` change on the same edge that raises `GP` or `AD`.
- Minimum spacing between `AD` pulses is 2 cycles.
- With `PG`/`CH` asserted as early as possible, a bottle takes ≥ 1 (MOVE) + 1 (FILL) + SEAL_CYCLES + 1 (EJECT) cycles.

## Test plan
- Normal cycle, defaults: `run`=1, then `PG`=1, `CH`=1 after 5 cycles, then `PG`=0.
  - Required: `VE` high 4 cycles, one `GP`, `tray_count` 20→19, FSM back in MOVE.
- Low mark: produce 15 bottles.
  - Required: at `tray_count`=5, `AD` pulses once; tray becomes 20, `stock_count` becomes 45.
  - When the tray reaches 5 again, the next refill also adds 15 (20, 30).
- Exhaustion: `DISP_STOCK`=0, produce 20 bottles.
  - Required: after the 20th `GP`, ALARM with code 10.
  - `alarm_clr` alone has no effect; `stock_load` then `alarm_clr` → IDLE.
- Fill timeout: `FILL_TIMEOUT`=16, `PG`=1, `CH` held at 0.
  - Required: after 16 FILL cycles, `A`=1 and code 01; `EV`=0.
  - `alarm_clr` → IDLE; `tray_count` unchanged.
- BCD wrap: `CNT_DIGITS`=1, `BATCH`=2, ample stock, 20 bottles.
  - Required: `dozen_bcd` counts 1..9, then 0; 10 increments total.
- Reset mid-FILL: assert `reset` for 1 cycle.
  - Required: all outputs go to reset values at once, no `GP` pulse, `tray_count`=TRAY_CAP.
